// File: rtl/prach_pkg.sv
// -----------------------------------------------------------------------------
// prach_pkg
// Shared types and constants for the PRACH decimation chain.
//   NumChannel     : TDM slots per frame
//   NumChannelUsed : leading slots that carry PRACH data
//   sample_t       : signed 16-bit sample
//   chn_t          : 8-bit TDM channel index
//   phase_t        : frame parity used by the polyphase pairing stage
// -----------------------------------------------------------------------------
package prach_pkg;

    localparam int NumChannel     = 128;
    localparam int NumChannelUsed = 48;

    typedef logic signed [15:0] sample_t;
    typedef logic [7:0]         chn_t;

    // Even frames are stored, odd frames are paired with the stored sample.
    typedef enum logic {
        PH_STORE = 1'b0,
        PH_EMIT  = 1'b1
    } phase_t;

endpackage

// File: rtl/prach_hb4_pair_buf.sv
// -----------------------------------------------------------------------------
// prach_hb4_pair_buf
// Simple dual-port sample buffer (one write port, one read port) with a
// 1-cycle registered read. Sized for distributed RAM.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata updates one cycle after re
//   raddr : read address
//   rdata : registered read data (holds when re is low)
// -----------------------------------------------------------------------------
module prach_hb4_pair_buf #(
    parameter int DEPTH = 48,
    parameter int WIDTH = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array and its read register carry no reset; a reset
    // would prevent mapping onto RAM primitives, and the pairing logic never
    // reads an entry before writing it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prach_hb4_pair.sv
// -----------------------------------------------------------------------------
// prach_hb4_pair
// Polyphase pairing stage ahead of the PRACH 4th half-band decimator.
// Even-frame samples of each used channel are buffered; on the following odd
// frame the stored sample and the new one are emitted together as a pair.
// Fixed latency of 2 cycles from input to output.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   din_dq   : input sample
//   din_dv   : input valid
//   din_chn  : TDM channel of din_dq
//   sync_in  : frame alignment pulse, with the channel-0 sample
//   dout_dp1 : later (odd-frame) sample of the pair
//   dout_dp2 : earlier (even-frame) sample of the pair
//   dout_dv  : pair valid
//   dout_chn : channel of the pair (2-cycle delay of din_chn)
//   sync_out : 2-cycle delay of sync_in
//   err      : sticky sequencing error
//
// Build option: define PRACH_HB4_PAIR_ERRCHK_EN to build the channel-order
// checker driving err; otherwise err is tied low.
// -----------------------------------------------------------------------------
module prach_hb4_pair
    import prach_pkg::*;
#(
    parameter int NUM_CHANNEL      = NumChannel,
    parameter int NUM_CHANNEL_USED = NumChannelUsed,
    parameter int WIDTH            = $bits(sample_t)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] din_dq,
    input  logic                    din_dv,
    input  logic [7:0]              din_chn,
    input  logic                    sync_in,
    output logic signed [WIDTH-1:0] dout_dp1,
    output logic signed [WIDTH-1:0] dout_dp2,
    output logic                    dout_dv,
    output logic [7:0]              dout_chn,
    output logic                    sync_out,
    output logic                    err
);

    // A frame cannot carry more used channels than it has slots.
    localparam int   UsedCnt   = (NUM_CHANNEL_USED < NUM_CHANNEL) ? NUM_CHANNEL_USED
                                                                  : NUM_CHANNEL;
    localparam int   AW        = (UsedCnt > 1) ? $clog2(UsedCnt) : 1;
    localparam chn_t UsedLimit = chn_t'(UsedCnt);
    localparam chn_t LastChn   = chn_t'(UsedCnt - 1);

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    phase_t phase;
    phase_t phase_eff;
    phase_t phase_nxt;
    logic   used;
    logic   wr_en;
    logic   rd_en;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        // sync forces the even phase before the accompanying sample is used,
        // which also discards any half-collected odd frame.
        phase_eff = sync_in ? PH_STORE : phase;
        used      = din_dv && (din_chn < UsedLimit);
        wr_en     = used && (phase_eff == PH_STORE);
        rd_en     = used && (phase_eff == PH_EMIT);
        phase_nxt = phase_eff;
        if (used && (din_chn == LastChn)) begin
            phase_nxt = (phase_eff == PH_STORE) ? PH_EMIT : PH_STORE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_STORE;
        end else begin
            phase <= phase_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer: written in the even phase, read in the odd phase, so a
    // read and a write never target the same entry in the same cycle.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rd_data;

    prach_hb4_pair_buf #(
        .DEPTH (UsedCnt),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (din_chn[AW-1:0]),
        .wdata (din_dq),
        .re    (rd_en),
        .raddr (din_chn[AW-1:0]),
        .rdata (rd_data)
    );

    // ------------------------------------------------------------------
    // Output pipeline. Stage 1 lines the input up with the registered RAM
    // read; stage 2 is the output register.
    // ------------------------------------------------------------------
    logic                    s1_emit;
    logic signed [WIDTH-1:0] s1_dq;
    logic [7:0]              s1_chn;
    logic                    s1_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_emit  <= 1'b0;
            s1_dq    <= '0;
            s1_chn   <= '0;
            s1_sync  <= 1'b0;
            dout_dv  <= 1'b0;
            dout_chn <= '0;
            sync_out <= 1'b0;
            dout_dp1 <= '0;
            dout_dp2 <= '0;
        end else begin
            s1_emit  <= rd_en;
            s1_dq    <= din_dq;
            s1_chn   <= din_chn;
            s1_sync  <= sync_in;
            dout_dv  <= s1_emit;
            dout_chn <= s1_chn;
            sync_out <= s1_sync;
            // Pair data holds between pairs.
            if (s1_emit) begin
                dout_dp1 <= s1_dq;
                dout_dp2 <= $signed(rd_data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel-order checker
    // ------------------------------------------------------------------
`ifdef PRACH_HB4_PAIR_ERRCHK_EN
    chn_t exp_chn;
    chn_t exp_eff;
    chn_t exp_nxt;
    logic seq_bad;

    always_comb begin
        exp_eff = sync_in ? '0 : exp_chn;
        exp_nxt = exp_eff;
        if (used) begin
            exp_nxt = (exp_eff == LastChn) ? '0 : exp_eff + 8'd1;
        end
        seq_bad = (used && (din_chn != exp_eff)) ||
                  (sync_in && din_dv && (din_chn != 8'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_chn <= '0;
            err     <= 1'b0;
        end else begin
            exp_chn <= exp_nxt;
            err     <= err | seq_bad;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prach_hb4_pair.sv
// -----------------------------------------------------------------------------
// tb_prach_hb4_pair
// Self-checking bench for prach_hb4_pair: a short vector table for the
// sideband, directed frame sequences, and a cycle-by-cycle comparison against
// a frame-level reference model (stored samples per channel plus a queue of
// expected pairs stamped with their due cycle).
// -----------------------------------------------------------------------------
module tb_prach_hb4_pair;
    import prach_pkg::*;

    localparam int USED = NumChannelUsed;
    localparam int NCH  = NumChannel;

    logic    clk = 1'b0;
    logic    rst;
    sample_t din_dq;
    logic    din_dv;
    chn_t    din_chn;
    logic    sync_in;
    sample_t dout_dp1;
    sample_t dout_dp2;
    logic    dout_dv;
    chn_t    dout_chn;
    logic    sync_out;
    logic    err;

    always #5 clk = ~clk;

    prach_hb4_pair dut (
        .clk      (clk),
        .rst      (rst),
        .din_dq   (din_dq),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;
    int pair_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int      due;
        chn_t    chn;
        sample_t dp1;
        sample_t dp2;
    } pair_t;

    pair_t   pq[$];
    sample_t m_store [USED];
    bit      m_odd;
    int      m_exp;
    bit      m_err;
    sample_t last_dp1;
    sample_t last_dp2;
    int      cyc = 0;
    bit      h_sync [4];
    chn_t    h_chn  [4];

    task automatic model_reset();
        pq.delete();
        last_dp1 = '0;
        last_dp2 = '0;
        m_odd    = 1'b0;
        m_exp    = 0;
        m_err    = 1'b0;
    endtask

    // Asynchronous reset wipes the whole in-flight pipeline immediately.
    always @(posedge rst) begin
        model_reset();
        h_sync[cyc & 3]       = 1'b0;
        h_chn[cyc & 3]        = '0;
        h_sync[(cyc - 1) & 3] = 1'b0;
        h_chn[(cyc - 1) & 3]  = '0;
    end

    always @(posedge clk) begin
        bit odd;
        int expc;
        bit use_it;
        cyc++;
        if (rst) begin
            model_reset();
            h_sync[cyc & 3] = 1'b0;
            h_chn[cyc & 3]  = '0;
        end else begin
            h_sync[cyc & 3] = sync_in;
            h_chn[cyc & 3]  = din_chn;
            odd    = sync_in ? 1'b0 : m_odd;
            expc   = sync_in ? 0 : m_exp;
            use_it = din_dv && (int'(din_chn) < USED);
            if (sync_in && din_dv && din_chn != 0) m_err = 1'b1;
            if (use_it) begin
                if (int'(din_chn) != expc) m_err = 1'b1;
                if (!odd) m_store[din_chn] = din_dq;
                else pq.push_back('{cyc + 1, din_chn, din_dq, m_store[din_chn]});
                if (int'(din_chn) == USED - 1) odd = !odd;
                expc = (expc + 1) % USED;
            end
            m_odd = odd;
            m_exp = expc;
        end
    end

    // Outputs seen in a cycle reflect the inputs present two cycles earlier.
    always @(negedge clk) begin
        bit exp_dv;
        bit exp_err;
        exp_dv = (pq.size() > 0) && (pq[0].due == cyc);
        if (exp_dv) begin
            last_dp1 = pq[0].dp1;
            last_dp2 = pq[0].dp2;
            void'(pq.pop_front());
        end
`ifdef PRACH_HB4_PAIR_ERRCHK_EN
        exp_err = m_err;
`else
        exp_err = 1'b0;
`endif
        check("mon_dv",   dout_dv,  exp_dv);
        check("mon_sync", sync_out, h_sync[(cyc - 1) & 3]);
        check("mon_chn",  dout_chn, h_chn[(cyc - 1) & 3]);
        check("mon_dp1",  dout_dp1, last_dp1);
        check("mon_dp2",  dout_dp2, last_dp2);
        check("mon_err",  err,      exp_err);
        if (dout_dv) pair_cnt++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input bit s, input bit v, input int c, input int d);
        @(posedge clk);
        #1;
        sync_in = s;
        din_dv  = v;
        din_chn = chn_t'(c);
        din_dq  = sample_t'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom));
    endtask

    // One frame of channels 0..last_ch; optional random valid gaps and data.
    task automatic frame(input int base, input bit gaps, input bit do_sync,
                         input int last_ch, input bit rnd);
        for (int ch = 0; ch <= last_ch; ch++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) idle(1);
            end
            drive(do_sync && (ch == 0), 1'b1, ch, rnd ? int'($urandom) : base + ch);
        end
    endtask

    // ------------------------------------------------------------------
    // Sideband vector table: expected outputs are those of the entry two
    // rows earlier (rows before the table are idle).
    // ------------------------------------------------------------------
    typedef struct {
        bit   sync;
        bit   dv;
        chn_t chn;
        int   dq;
        bit   exp_sync_out;
        bit   exp_dv;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'd0, 0,  1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'd9, 5,  1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'd0, 77, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'd3, 0,  1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'd0, 0,  1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'd0, 0,  1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'd0, 0,  1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'd0, 0,  1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 8'd0, 0,  1'b1, 1'b0};
        // tbl[8] expects entry 6 (0); fix expectations to the two-row delay.
        tbl[8].exp_sync_out = tbl[6].sync;

        rst     = 1'b1;
        sync_in = 1'b0;
        din_dv  = 1'b0;
        din_chn = '0;
        din_dq  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dv",   dout_dv,  1'b0);
        check("rst_dp1",  dout_dp1, 32'd0);
        check("rst_dp2",  dout_dp2, 32'd0);
        check("rst_chn",  dout_chn, 32'd0);
        check("rst_sync", sync_out, 1'b0);
        check("rst_err",  err,      1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);

        // Sideband table: sync_out must track sync_in even with din_dv low.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].sync, tbl[i].dv, int'(tbl[i].chn), tbl[i].dq);
            @(negedge clk);
            check($sformatf("tbl%0d_sync", i), sync_out, tbl[i].exp_sync_out);
            check($sformatf("tbl%0d_dv", i),   dout_dv,  tbl[i].exp_dv);
        end
        idle(3);

        // Contiguous even/odd frame pair.
        pair_cnt = 0;
        frame(0, 1'b0, 1'b1, NCH - 1, 1'b0);
        check("even_no_pairs", pair_cnt, 32'd0);
        frame(1000, 1'b0, 1'b0, NCH - 1, 1'b0);
        idle(3);
        check("basic_pairs", pair_cnt, 32'd48);
        check("basic_last_dp1", dout_dp1, 32'd1047);
        check("basic_last_dp2", dout_dp2, 32'd47);

        // Same with random valid gaps.
        pair_cnt = 0;
        frame(0, 1'b1, 1'b1, NCH - 1, 1'b0);
        frame(1000, 1'b1, 1'b0, NCH - 1, 1'b0);
        idle(3);
        check("gap_pairs", pair_cnt, 32'd48);

        // Sync mid odd frame: partial frame pairs, next frame stored only.
        pair_cnt = 0;
        frame(0, 1'b0, 1'b1, NCH - 1, 1'b0);
        frame(1000, 1'b0, 1'b0, 20, 1'b0);
        frame(2000, 1'b0, 1'b1, NCH - 1, 1'b0);
        idle(3);
        check("resync_partial", pair_cnt, 32'd21);
        frame(3000, 1'b0, 1'b0, NCH - 1, 1'b0);
        idle(3);
        check("resync_resume", pair_cnt, 32'd69);
        check("resync_dp2", dout_dp2, 32'd2047);

        // One-cycle reset during the odd frame.
        frame(0, 1'b0, 1'b1, NCH - 1, 1'b0);
        frame(1000, 1'b0, 1'b0, 30, 1'b0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        sync_in = 1'b0;
        din_dv  = 1'b0;
        @(negedge clk);
        check("midrst_dv",  dout_dv,  1'b0);
        check("midrst_dp1", dout_dp1, 32'd0);
        check("midrst_dp2", dout_dp2, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pair_cnt = 0;
        frame(5000, 1'b0, 1'b1, NCH - 1, 1'b0);
        idle(3);
        check("postrst_even", pair_cnt, 32'd0);
        frame(6000, 1'b0, 1'b0, NCH - 1, 1'b0);
        idle(3);
        check("postrst_pairs", pair_cnt, 32'd48);

        // Random data with gaps, two even/odd pairs.
        pair_cnt = 0;
        frame(0, 1'b1, 1'b1, NCH - 1, 1'b1);
        frame(0, 1'b1, 1'b0, NCH - 1, 1'b1);
        frame(0, 1'b1, 1'b0, NCH - 1, 1'b1);
        frame(0, 1'b1, 1'b0, NCH - 1, 1'b1);
        idle(3);
        check("rand_pairs", pair_cnt, 32'd96);
        check("rand_err_clean", err, 1'b0);

        // Skip channel 5 in the odd frame.
        pair_cnt = 0;
        frame(0, 1'b0, 1'b1, NCH - 1, 1'b0);
        for (int ch = 0; ch < NCH; ch++) begin
            if (ch == 5) continue;
            drive(1'b0, 1'b1, ch, 4000 + ch);
            if (ch == 6) begin
                @(negedge clk);
                check("err_before_skip", err, 1'b0);
            end
            if (ch == 7) begin
                @(negedge clk);
`ifdef PRACH_HB4_PAIR_ERRCHK_EN
                check("err_after_skip", err, 1'b1);
`else
                check("err_after_skip", err, 1'b0);
`endif
            end
        end
        idle(5);
        check("skip_pairs", pair_cnt, 32'd47);
`ifdef PRACH_HB4_PAIR_ERRCHK_EN
        check("err_held", err, 1'b1);
`else
        check("err_held", err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
